dezigzag: RTL and testbench

Inverse zigzag reorder buffer for the JPEG decode path. It accepts quantized-domain coefficients in JPEG zigzag order, two per cycle, and reassembles each 8×8 block into raster order. It emits one row of eight coefficients per transfer into the first 1-D IDCT pass. It is the read-side counterpart of the encoder's zigzag stage and uses the same valid/hold streaming handshake.

---
 rtl/jenc_pkg.sv | 18 +
 rtl/dezigzag_bank.sv | 34 +++
 rtl/dezigzag.sv | 116 +++++++++++
 tb/tb_dezigzag.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jenc_pkg.sv
// Shared JPEG codec constants: coefficient width and the zigzag-index to raster-address table.
// The encoder zigzag stage and the decoder dezigzag stage both read ZZ from here.
package jenc_pkg;

  localparam int QW = 15;

  localparam logic [5:0] ZZ [64] = '{
     6'd0,  6'd1,  6'd8, 6'd16,  6'd9,  6'd2,  6'd3, 6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11,  6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13,  6'd6,  6'd7, 6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/dezigzag_bank.sv
// One 8x8 coefficient bank: two raster-addressed write ports and a combinational
// row read port returning the eight words of one raster row.
module dezigzag_bank
  import jenc_pkg::*;
#(
  parameter int QW = jenc_pkg::QW
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [5:0]           waddr0_i,
  input  logic [5:0]           waddr1_i,
  input  logic signed [QW-1:0] wdata0_i,
  input  logic signed [QW-1:0] wdata1_i,
  input  logic [2:0]           row_i,
  output logic signed [QW-1:0] row_o [8]
);

  logic signed [QW-1:0] mem_q [64];

  // NOTE: the array has no reset; full flags gate every read, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr0_i] <= wdata0_i;
      mem_q[waddr1_i] <= wdata1_i;
    end
  end

  always_comb begin
    for (int c = 0; c < 8; c++) begin
      row_o[c] = mem_q[{row_i, c[2:0]}];
    end
  end

endmodule

// File: rtl/dezigzag.sv
// Inverse zigzag reorder buffer: ping-pong 8x8 banks filled two coefficients per
// cycle in zigzag order, drained one raster row per transfer.
module dezigzag
  import jenc_pkg::*;
#(
  parameter int QW = jenc_pkg::QW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [QW-1:0] d [2],
  input  logic                 d_valid,
  output logic                 d_hold,
  input  logic [4:0]           d_cnt,
  output logic signed [QW-1:0] q [8],
  output logic                 q_valid,
  input  logic                 q_hold,
  output logic [2:0]           q_cnt
);

  logic [1:0]           full_q, full_d;
  logic                 wb_q, wb_d, rb_q, rb_d;
  logic [2:0]           r_q, r_d;
  logic                 q_valid_q, q_valid_d;
  logic [2:0]           q_cnt_q, q_cnt_d;
  logic signed [QW-1:0] q_q [8];
  logic signed [QW-1:0] q_d [8];
  logic signed [QW-1:0] row0 [8];
  logic signed [QW-1:0] row1 [8];
  logic                 in_xfer, blk_done, rd_avail, fire;
  logic [5:0]           waddr0, waddr1;

  assign d_hold  = full_q[wb_q];
  assign in_xfer = d_valid && !d_hold;
  assign waddr0  = ZZ[{d_cnt, 1'b0}];
  assign waddr1  = ZZ[{d_cnt, 1'b1}];

  dezigzag_bank #(.QW(QW)) u_bank0 (
    .clk      (clk),
    .we_i     (in_xfer && !wb_q),
    .waddr0_i (waddr0),
    .waddr1_i (waddr1),
    .wdata0_i (d[0]),
    .wdata1_i (d[1]),
    .row_i    (r_q),
    .row_o    (row0)
  );

  dezigzag_bank #(.QW(QW)) u_bank1 (
    .clk      (clk),
    .we_i     (in_xfer && wb_q),
    .waddr0_i (waddr0),
    .waddr1_i (waddr1),
    .wdata0_i (d[0]),
    .wdata1_i (d[1]),
    .row_i    (r_q),
    .row_o    (row1)
  );

  // Raster row 0 never holds zigzag 62/63, so it can load on the edge the final pair lands.
  assign blk_done = in_xfer && (d_cnt == 5'd31);
  assign rd_avail = full_q[rb_q] || (blk_done && (wb_q == rb_q));
  assign fire     = rd_avail && (!q_valid_q || !q_hold);

  // NOTE: every next-state signal gets a default first so this block cannot infer a latch.
  always_comb begin
    full_d    = full_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    r_d       = r_q;
    q_valid_d = q_valid_q;
    q_cnt_d   = q_cnt_q;
    q_d       = q_q;
    if (blk_done) begin
      full_d[wb_q] = 1'b1;
      wb_d         = !wb_q;
    end
    if (fire) begin
      q_d       = rb_q ? row1 : row0;
      q_cnt_d   = r_q;
      q_valid_d = 1'b1;
      r_d       = r_q + 3'd1;
      if (r_q == 3'd7) begin
        full_d[rb_q] = 1'b0;
        rb_d         = !rb_q;
      end
    end else if (q_valid_q && !q_hold) begin
      q_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= 2'b00;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      r_q       <= 3'd0;
      q_valid_q <= 1'b0;
      q_cnt_q   <= 3'd0;
      q_q       <= '{default: '0};
    end else begin
      full_q    <= full_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      r_q       <= r_d;
      q_valid_q <= q_valid_d;
      q_cnt_q   <= q_cnt_d;
      q_q       <= q_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign q_cnt   = q_cnt_q;

endmodule

// File: tb/tb_dezigzag.sv
// Randomized bench for dezigzag: a queue of expected raster rows built from an
// independently generated zigzag walk, checked on every output transfer.
module tb_dezigzag;

  localparam int W = 15;
  typedef logic signed [W-1:0] coef_t;
  typedef struct packed {
    logic [2:0]        r;
    logic [7:0][W-1:0] v;
  } row_t;

  logic       clk = 1'b0;
  logic       reset;
  coef_t      d [2];
  logic       d_valid;
  logic       d_hold;
  logic [4:0] d_cnt;
  coef_t      q [8];
  logic       q_valid;
  logic       q_hold;
  logic [2:0] q_cnt;

  always #5 clk = ~clk;

  dezigzag #(.QW(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .d_valid (d_valid),
    .d_hold  (d_hold),
    .d_cnt   (d_cnt),
    .q       (q),
    .q_valid (q_valid),
    .q_hold  (q_hold),
    .q_cnt   (q_cnt)
  );

  int    vectors = 0;
  int    miscompares = 0;
  int    zz_ref [64];
  row_t  exp_q [$];
  coef_t cur [64];
  bit    have_block = 0;
  int    pair_idx = 0;
  int    xfer_cnt = 0;
  bit    prev_hold_v = 0;
  coef_t prev_q [8];
  logic [2:0] prev_cnt;
  logic  smp_dhold, smp_qvalid;
  logic [2:0] smp_qcnt;
  coef_t smp_q [8];

  // Walk the anti-diagonals of the 8x8 block, alternating direction.
  function automatic void build_zz();
    int k;
    int lo;
    int hi;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  task automatic push_block();
    coef_t ras [64];
    row_t  rw;
    for (int k = 0; k < 64; k++) ras[zz_ref[k]] = cur[k];
    for (int r = 0; r < 8; r++) begin
      rw.r = r[2:0];
      for (int c = 0; c < 8; c++) rw.v[c] = ras[8 * r + c];
      exp_q.push_back(rw);
    end
  endtask

  // kind 0: value k at index k; 1: random; 2: random with extremes at 0 and 63
  task automatic new_block(input int kind);
    for (int k = 0; k < 64; k++) begin
      if (kind == 0) cur[k] = coef_t'(k);
      else           cur[k] = coef_t'($urandom);
    end
    if (kind == 2) begin
      cur[0]  = -15'sd16384;
      cur[63] = 15'sd16383;
    end
    have_block = 1;
    pair_idx   = 0;
  endtask

  task automatic cycle(input bit want, input bit hold);
    row_t e;
    bit   bad;
    int   bc;
    @(negedge clk);
    q_hold  = hold;
    d_valid = want && have_block;
    d_cnt   = 5'(pair_idx);
    d[0]    = cur[(2 * pair_idx) % 64];
    d[1]    = cur[(2 * pair_idx + 1) % 64];
    smp_dhold  = d_hold;
    smp_qvalid = q_valid;
    smp_qcnt   = q_cnt;
    smp_q      = q;
    if (prev_hold_v) begin
      vectors++;
      bad = (q_valid !== 1'b1) || (q_cnt !== prev_cnt);
      for (int c = 0; c < 8; c++) if (q[c] !== prev_q[c]) bad = 1;
      if (bad) begin
        miscompares++;
        $display("FAIL hold_stable: q_valid=%0b q_cnt=%0d q0=%0d, required q_valid=1 q_cnt=%0d q0=%0d",
                 q_valid, q_cnt, q[0], prev_cnt, prev_q[0]);
      end
    end
    if (q_valid === 1'b1 && !hold) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL row_unexpected: q_cnt=%0d q0=%0d, required no output row", q_cnt, q[0]);
      end else begin
        e   = exp_q.pop_front();
        bad = (q_cnt !== e.r);
        bc  = 0;
        for (int c = 7; c >= 0; c--) if (q[c] !== coef_t'(e.v[c])) begin bad = 1; bc = c; end
        if (bad) begin
          miscompares++;
          $display("FAIL row_data: q_cnt=%0d q[%0d]=%0d, required q_cnt=%0d q[%0d]=%0d",
                   q_cnt, bc, q[bc], e.r, bc, coef_t'(e.v[bc]));
        end
      end
    end
    prev_hold_v = (q_valid === 1'b1) && hold;
    prev_q      = q;
    prev_cnt    = q_cnt;
    if (d_valid && d_hold === 1'b0) begin
      xfer_cnt++;
      pair_idx++;
      if (pair_idx == 32) begin
        push_block();
        have_block = 0;
        pair_idx   = 0;
      end
    end
  endtask

  // mode 0: stream, q_hold=0; 1: stream, q_hold=1; 2: random valid/hold
  task automatic feed(input int mode);
    int n;
    n = 0;
    while (have_block && n < 5000) begin
      if (mode == 2) cycle($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 30);
      else           cycle(1'b1, mode == 1);
      n++;
    end
    vectors++;
    if (have_block) begin
      miscompares++;
      $display("FAIL feed_timeout: pair_idx=%0d after %0d cycles, required block accepted", pair_idx, n);
      have_block = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && smp_qvalid === 1'b0) && n < 400) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || smp_qvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d rows outstanding q_valid=%0b, required 0 rows q_valid=0",
               exp_q.size(), smp_qvalid);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bit bad;
    @(negedge clk);
    reset   = 1'b1;
    d_valid = 1'b0;
    q_hold  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (q_valid !== 1'b0) begin miscompares++; $display("FAIL reset_q_valid: got %0b, required 0", q_valid); end
    vectors++;
    if (d_hold !== 1'b0) begin miscompares++; $display("FAIL reset_d_hold: got %0b, required 0", d_hold); end
    vectors++;
    if (q_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_q_cnt: got %0d, required 0", q_cnt); end
    vectors++;
    bad = 0;
    for (int c = 0; c < 8; c++) if (q[c] !== '0) bad = 1;
    if (bad) begin miscompares++; $display("FAIL reset_q: q0=%0d q7=%0d, required all 0", q[0], q[7]); end
    exp_q.delete();
    have_block  = 0;
    pair_idx    = 0;
    prev_hold_v = 0;
    smp_qvalid  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_identity();
    int  r0 [8] = '{0, 1, 5, 6, 14, 15, 27, 28};
    int  r7 [8] = '{35, 36, 48, 49, 57, 58, 62, 63};
    bit  bad;
    int  n;
    new_block(0);
    feed(0);
    cycle(1'b0, 1'b0);
    vectors++;
    if (smp_qvalid !== 1'b1 || smp_qcnt !== 3'd0) begin
      miscompares++;
      $display("FAIL identity_latency: q_valid=%0b q_cnt=%0d, required q_valid=1 q_cnt=0", smp_qvalid, smp_qcnt);
    end
    vectors++;
    bad = 0;
    for (int c = 0; c < 8; c++) if (smp_q[c] !== coef_t'(r0[c])) bad = 1;
    if (bad) begin
      miscompares++;
      $display("FAIL identity_row0: got %0d %0d %0d %0d %0d %0d %0d %0d, required 0 1 5 6 14 15 27 28",
               smp_q[0], smp_q[1], smp_q[2], smp_q[3], smp_q[4], smp_q[5], smp_q[6], smp_q[7]);
    end
    n = 0;
    while (!(smp_qvalid === 1'b1 && smp_qcnt === 3'd7) && n < 20) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    vectors++;
    bad = (n >= 20);
    for (int c = 0; c < 8; c++) if (smp_q[c] !== coef_t'(r7[c])) bad = 1;
    if (bad) begin
      miscompares++;
      $display("FAIL identity_row7: q_cnt=%0d got %0d %0d %0d %0d %0d %0d %0d %0d, required 35 36 48 49 57 58 62 63",
               smp_qcnt, smp_q[0], smp_q[1], smp_q[2], smp_q[3], smp_q[4], smp_q[5], smp_q[6], smp_q[7]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int n;
    for (int b = 0; b < 3; b++) begin
      new_block(1);
      n = 0;
      while (have_block && n < 100) begin
        cycle(1'b1, 1'b0);
        n++;
        vectors++;
        if (smp_dhold !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_d_hold: block %0d pair %0d d_hold=%0b, required 0", b, pair_idx, smp_dhold);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int base;
    base = xfer_cnt;
    new_block(1);
    feed(1);
    new_block(1);
    feed(1);
    vectors++;
    if (xfer_cnt - base != 64) begin
      miscompares++;
      $display("FAIL bp_count: %0d transfers, required 64", xfer_cnt - base);
    end
    new_block(1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1);
      vectors++;
      if (smp_dhold !== 1'b1 || smp_qvalid !== 1'b1 || smp_qcnt !== 3'd0 || pair_idx != 0) begin
        miscompares++;
        $display("FAIL bp_stall: d_hold=%0b q_valid=%0b q_cnt=%0d pairs=%0d, required 1 1 0 0",
                 smp_dhold, smp_qvalid, smp_qcnt, pair_idx);
      end
    end
    feed(0);
    drain();
  endtask

  task automatic test_random();
    for (int b = 0; b < 1000; b++) begin
      new_block(1);
      feed(2);
    end
    drain();
  endtask

  task automatic test_extremes();
    bit s0, s7;
    int n;
    s0 = 0;
    s7 = 0;
    new_block(2);
    feed(0);
    n = 0;
    while (!s7 && n < 20) begin
      cycle(1'b0, 1'b0);
      n++;
      if (smp_qvalid === 1'b1 && smp_qcnt === 3'd0 && !s0) begin
        s0 = 1;
        vectors++;
        if (smp_q[0] !== -15'sd16384) begin
          miscompares++;
          $display("FAIL extreme_min: q[0]=%0d, required -16384", smp_q[0]);
        end
      end
      if (smp_qvalid === 1'b1 && smp_qcnt === 3'd7) begin
        s7 = 1;
        vectors++;
        if (smp_q[7] !== 15'sd16383) begin
          miscompares++;
          $display("FAIL extreme_max: q[7]=%0d, required 16383", smp_q[7]);
        end
      end
    end
    vectors++;
    if (!(s0 && s7)) begin
      miscompares++;
      $display("FAIL extreme_rows: seen row0=%0b row7=%0b, required both", s0, s7);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int n;
    new_block(1);
    feed(1);
    new_block(1);
    n = 0;
    while (pair_idx <= 17 && n < 100) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    do_reset();
    new_block(1);
    feed(0);
    drain();
  endtask

  initial begin
    reset   = 1'b0;
    d_valid = 1'b0;
    q_hold  = 1'b0;
    d_cnt   = 5'd0;
    d[0]    = '0;
    d[1]    = '0;
    build_zz();
    test_reset();
    test_identity();
    test_back_to_back();
    test_backpressure();
    test_extremes();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
